// File: rtl/chunked_add_seq_pkg.sv
// Shared types and defaults for the chunked sequential adder.
// State encoding, default geometry and the chunk-count helper live here.
package chunked_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_CHUNK = 3;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit combinational ripple adder slice, reused every cycle by chunked_add_seq.
module add_chunk #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle wide adder: one add_chunk slice walks LSB-first over WIDTH/CHUNK cycles.
// Define CHUNKED_ADD_SEQ_SUB_EN to add an `op` port selecting a - b (op=1).
module chunked_add_seq
  import chunked_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (NCHUNK < 1)) begin : g_bad_cfg
      $error("chunked_add_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic            carry_reg, cout_reg;
  logic [IDXW-1:0] idx_reg;
  logic            accept;
  logic            last_chunk;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] a_sel, b_sel, s_chunk;
  logic             c_chunk;

  // Operand registers viewed as an array of slices so the active one is a plain index.
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign a_sel = a_chunks[idx_reg];
  assign b_sel = b_chunks[idx_reg];

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (carry_reg),
    .sum  (s_chunk),
    .cout (c_chunk)
  );

  // in_ready is masked by rst so nothing can be accepted while reset is asserted.
  assign in_ready   = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx_reg == LAST_IDX);

  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = BUSY;
      BUSY: if (last_chunk) state_next = DONE;
      DONE: begin
        if (accept)         state_next = BUSY;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      a_reg   <= a;
      idx_reg <= '0;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
      // Subtraction as a + ~b + 1; cout then reads as "no borrow".
      b_reg     <= op ? ~b : b;
      carry_reg <= op ? 1'b1 : cin;
`else
      b_reg     <= b;
      carry_reg <= cin;
`endif
    end else if (state_reg == BUSY) begin
      sum_reg[int'(idx_reg)*CHUNK +: CHUNK] <= s_chunk;
      carry_reg <= c_chunk;
      if (last_chunk) begin
        cout_reg <= c_chunk;
        idx_reg  <= '0;
      end else begin
        idx_reg  <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed bench for chunked_add_seq (WIDTH=12, CHUNK=3): vector table plus
// hand-written backpressure, back-to-back and mid-operation reset sequences.
module tb_chunked_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sum;
  logic        cout;
  logic        busy;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  logic        op;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic [11:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [8];

  chunked_add_seq #(.WIDTH(12), .CHUNK(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called one cycle after the accepting edge; waits for out_valid within a bound.
  task automatic wait_result(input string name, input logic [11:0] es, input logic ec);
    int lat = 0;
    int busy_n = 0;
    int ir_n = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_n++;
      if (in_ready) ir_n++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_busy_cycles"}, busy_n, 4);
    chk({name, "_in_ready_busy"}, ir_n, 0);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_busy_done"}, busy, 0);
    $display("op %s: sum=%03h cout=%0b latency=%0d", name, sum, cout, lat);
  endtask

  task automatic start_op(input logic [11:0] va, input logic [11:0] vb, input logic vc);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_released"}, out_valid, 0);
  endtask

  task automatic do_op(input string name, input logic [11:0] va, input logic [11:0] vb,
                       input logic vc, input logic [11:0] es, input logic ec);
    chk({name, "_idle_ready"}, in_ready, 1);
    start_op(va, vb, vc);
    wait_result(name, es, ec);
    release_result(name);
  endtask

  initial begin
    vecs[0] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
    vecs[1] = '{12'h123, 12'h456, 1'b1, 12'h57A, 1'b0};
    vecs[2] = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0};
    vecs[3] = '{12'h000, 12'h000, 1'b1, 12'h001, 1'b0};
    vecs[4] = '{12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1};
    vecs[5] = '{12'h555, 12'hAAA, 1'b0, 12'hFFF, 1'b0};
    vecs[6] = '{12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1};
    vecs[7] = '{12'h0A5, 12'h05A, 1'b0, 12'h0FF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    op = 1'b0;
`endif
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Backpressure: result and flags hold while out_ready stays low.
    chk("bp_idle_ready", in_ready, 1);
    start_op(12'h321, 12'h123, 1'b0);
    wait_result("bp", 12'h444, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = 12'(i * 12'h111 + 12'h0F0); b = ~a; cin = i[0]; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 12'h444);
      chk("bp_hold_cout", cout, 0);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    $display("op bp_hold: sum=%03h cout=%0b held 5 cycles", sum, cout);

    // Back-to-back: release the held result and accept a new operation on one edge.
    a = 12'h800; b = 12'h800; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; a = 12'h7FF; b = 12'h7FF; cin = 1'b1;
    chk("b2b_busy", busy, 1);
    chk("b2b_out_valid", out_valid, 0);
    wait_result("b2b", 12'h000, 1'b1);
    release_result("b2b");

    // Reset after two chunks of 0FF+0FF have been processed.
    start_op(12'h0FF, 12'h0FF, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_after", in_ready, 1);
    chk("midrst_idle_busy", busy, 0);
    $display("op midrst: outputs cleared, in_ready=%0b", in_ready);
    do_op("after_rst", 12'h00F, 12'h001, 1'b0, 12'h010, 1'b0);

`ifdef CHUNKED_ADD_SEQ_SUB_EN
    op = 1'b1;
    do_op("sub_5_7", 12'h005, 12'h007, 1'b0, 12'hFFE, 1'b0);
    do_op("sub_7_5", 12'h007, 12'h005, 1'b1, 12'h002, 1'b1);
    op = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
